// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch and decode stages.
// Word width, PC step, NOP word and the IF/ID bundle.
package fetch_stage_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, imem port and IF/ID outputs.
// master = fetch stage, slave = its environment.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              freeze;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_addr;
    logic [WORD_W-1:0] inst_in;
    logic [WORD_W-1:0] pc_out;
    logic [WORD_W-1:0] if_id_pc;
    logic [WORD_W-1:0] if_id_inst;
    logic              if_id_valid;
    logic [WORD_W-1:0] fetch_count;

    modport master (
        input  freeze, branch_taken, branch_addr, inst_in,
        output pc_out, if_id_pc, if_id_inst, if_id_valid, fetch_count
    );

    modport slave (
        output freeze, branch_taken, branch_addr, inst_in,
        input  pc_out, if_id_pc, if_id_inst, if_id_valid, fetch_count
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic IF/ID pipeline register with flush and freeze.
// Flush beats freeze; reset and flush load a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP = NOP_INST
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   freeze,
    input  if_id_t d,
    output if_id_t q,
    output logic   load
);

    // A new entry is accepted only when nothing blocks the edge.
    assign load = !rst && !flush && !freeze;

    // Bubble on reset/flush, hold on freeze, otherwise capture.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q.pc    <= '0;
            q.inst  <= NOP;
            q.valid <= 1'b0;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux,
// IF/ID register and accepted-instruction counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    import fetch_stage_pkg::*;

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] pc_d;
    logic [WORD_W-1:0] cnt_q;
    logic              load;
    if_id_t            ifid_d;
    if_id_t            ifid_q;

    assign pc_next = pc_q + PC_STEP;

    // Next-PC mux: redirect wins over stall.
    always_comb begin
        pc_d = pc_next;
        if (bus.branch_taken)
            pc_d = {bus.branch_addr[WORD_W-1:2], 2'b00};
        else if (bus.freeze)
            pc_d = pc_q;
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign ifid_d.pc    = pc_next;
    assign ifid_d.inst  = bus.inst_in;
    assign ifid_d.valid = 1'b1;

    if_id_reg #(
        .NOP (NOP_INST)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.branch_taken),
        .freeze (bus.freeze),
        .d      (ifid_d),
        .q      (ifid_q),
        .load   (load)
    );

    // Count instructions accepted into IF/ID.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.pc_out      = pc_q;
    assign bus.if_id_pc    = ifid_q.pc;
    assign bus.if_id_inst  = ifid_q.inst;
    assign bus.if_id_valid = ifid_q.valid;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed plan
// followed by random freeze/branch/reset traffic.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus.inst_in = imem(bus.pc_out);

    exp_t q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies the fetch rules
    // to its own architectural state and queues the outcome.
    task automatic step(input logic r, input logic f,
                        input logic b, input logic [31:0] a);
        @(negedge clk);
        rst              = r;
        bus.freeze       = f;
        bus.branch_taken = b;
        bus.branch_addr  = a;
        if (r) begin
            m.pc = RST_PC; m.ipc = 0; m.inst = NOP;
            m.valid = 0;   m.cnt = 0;
        end else if (b) begin
            m.pc = a & ~32'd3;
            m.ipc = 0; m.inst = NOP; m.valid = 0;
        end else if (!f) begin
            m.inst  = imem(m.pc);
            m.pc    = m.pc + 32'd4;
            m.ipc   = m.pc;
            m.valid = 1;
            m.cnt   = m.cnt + 1;
        end
        q.push_back(m);
    endtask

    // Monitor: after every edge, compare against the oldest entry.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pc_out",      bus.pc_out,      e.pc);
            check("if_id_pc",    bus.if_id_pc,    e.ipc);
            check("if_id_inst",  bus.if_id_inst,  e.inst);
            check("if_id_valid", {31'd0, bus.if_id_valid},
                  {31'd0, e.valid});
            check("fetch_count", bus.fetch_count, e.cnt);
            if (bus.if_id_valid === 1'b0)
                check("bubble_nop", bus.if_id_inst, NOP);
        end
    end

    initial begin
        int r, f, b;
        logic [31:0] a;
        rst = 1'b1;
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr = '0;
        m = '{default: '0};

        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0093);
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_0040);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFE);
        repeat (3) step(0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_1234);
        repeat (4) step(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            b = ($urandom_range(0, 99) < 12);
            f = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                a = $urandom;
            step(r[0], f[0], b[0], a);
        end

        @(negedge clk);
        bus.freeze = 1'b0;
        bus.branch_taken = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++)
            @(posedge clk);
        #5;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
